// File: rtl/rs232_avs_responder.sv
// ============================================================================
// rs232_avs_responder : Avalon-MM slave emulating the RS232 UART register map,
// with RX/TX byte FIFOs facing a host stream. Optional: RS232_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs232_avs_responder #(
   parameter int RX_DEPTH    = 64,
   parameter int TX_DEPTH    = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        avm_clk,
   input  logic        avm_rst_n,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
   localparam logic [4:0] ADDR_RX     = 5'd0;
   localparam logic [4:0] ADDR_TX     = 5'd4;
   localparam logic [4:0] ADDR_STATUS = 5'd8;
   localparam logic [4:0] ADDR_RXCNT  = 5'd12;
   localparam logic [4:0] ADDR_TXCNT  = 5'd16;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  addr_q, addr_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        udf_q, udf_d;
   logic        rdy_en_q;

   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

   logic ack, rx_empty, rx_full, tx_empty, tx_full;
   logic rx_push, rx_pop, tx_push, tx_pop;
   logic unused_wdata_hi;

   assign unused_wdata_hi = ^avs_writedata[31:8];

   assign ack      = (state_q == S_ACK);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == TX_FULL_CNT);

   // A full RX FIFO still takes a host byte in the cycle the master pops.
   assign rx_pop   = ack && rd_q && (addr_q == ADDR_RX) && !rx_empty;
   assign rx_ready = rdy_en_q && (!rx_full || rx_pop);
   assign rx_push  = rx_valid && rx_ready;

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_mem_q[tx_rp_q];
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_push  = ack && wr_q && (addr_q == ADDR_TX) && (!tx_full || tx_pop);

   assign avs_waitrequest = !ack;

`ifdef RS232_STATS_EN
   logic [31:0] rx_pops_q, rx_pops_d, tx_pushes_q, tx_pushes_d;

   always_comb begin
      rx_pops_d   = rx_pops_q + {31'd0, rx_pop};
      tx_pushes_d = tx_pushes_q + {31'd0, tx_push};
   end

   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         rx_pops_q   <= '0;
         tx_pushes_q <= '0;
      end else begin
         rx_pops_q   <= rx_pops_d;
         tx_pushes_q <= tx_pushes_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      udf_d        = udf_q;
      avs_readdata = '0;
      case (state_q)
         S_IDLE: begin
            if (avs_read || avs_write) begin
               addr_d  = avs_address;
               rd_d    = avs_read;
               wr_d    = avs_write && !avs_read;
               wdata_d = avs_writedata[7:0];
               cnt_d   = 4'(WAIT_CYCLES);
               // Zero-wait TX writes into a full FIFO still need S_WAIT to stall.
               if (WAIT_CYCLES == 0 &&
                   !(avs_write && !avs_read && avs_address == ADDR_TX && tx_full))
                  state_d = S_ACK;
               else
                  state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0)
               cnt_d = cnt_q - 4'd1;
            else if (!(wr_q && addr_q == ADDR_TX && tx_full))
               state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
            if (rd_q) begin
               case (addr_q)
                  ADDR_RX: begin
                     if (!rx_empty) avs_readdata = {24'd0, rx_mem_q[rx_rp_q]};
                     else           udf_d = 1'b1;
                  end
                  ADDR_STATUS: begin
                     avs_readdata = {24'd0, !rx_empty, !tx_full, 5'd0, udf_q};
                     udf_d        = 1'b0;
                  end
`ifdef RS232_STATS_EN
                  ADDR_RXCNT: avs_readdata = rx_pops_q;
                  ADDR_TXCNT: avs_readdata = tx_pushes_q;
`endif
                  default: avs_readdata = '0;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
      rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
      tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
      tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
   end

   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         udf_q    <= 1'b0;
         rdy_en_q <= 1'b0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         udf_q    <= udf_d;
         rdy_en_q <= 1'b1;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   // Storage needs no reset: the counts alone define what is valid.
   always_ff @(posedge avm_clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
      if (tx_push) tx_mem_q[tx_wp_q] <= wdata_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_rs232_avs_responder.sv
// ============================================================================
// tb_rs232_avs_responder : directed self-checking bench for rs232_avs_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rs232_avs_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   rs232_avs_responder #(.RX_DEPTH(64), .TX_DEPTH(32), .WAIT_CYCLES(1)) dut (
      .avm_clk         (clk),
      .avm_rst_n       (rst_n),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .rx_valid        (rx_valid),
      .rx_data         (rx_data),
      .rx_ready        (rx_ready),
      .tx_valid        (tx_valid),
      .tx_data         (tx_data),
      .tx_ready        (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where waitrequest is low.
   task automatic xfer(input logic rd, input logic wr, input logic [4:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdat, output int lat);
      avs_read = rd; avs_write = wr; avs_address = addr; avs_writedata = wd;
      rdat = '0; lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); @(negedge clk);
         if (!avs_waitrequest) begin
            rdat = avs_readdata; lat = i;
            break;
         end
      end
      avs_read = 1'b0; avs_write = 1'b0;
      if (lat < 0) check("xfer_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d; int l;
      xfer(1'b1, 1'b0, addr, 32'd0, d, l);
      check(tag, d, exp);
   endtask

   task automatic wr_do(input logic [4:0] addr, input logic [7:0] data);
      logic [31:0] d; int l;
      xfer(1'b0, 1'b1, addr, {24'hABCDEF, data}, d, l);
   endtask

   task automatic host_push(input logic [7:0] b);
      bit done = 0;
      rx_valid = 1'b1; rx_data = b;
      for (int i = 0; i < 60 && !done; i++) begin
         if (rx_ready) done = 1;
         @(posedge clk); @(negedge clk);
      end
      rx_valid = 1'b0;
      if (!done) check("push_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      int lat, low_cnt, ntx, order_err, bad_rdy;
      logic [7:0] first_tx;
      bit acked;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
      check("rst_readdata", avs_readdata, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

      // Status after reset, latency, single-cycle ack
      xfer(1'b1, 1'b0, 5'd8, 32'd0, d, lat);
      check("status_init", d, 32'h40);
      check("latency", lat, 32'd3);
      @(posedge clk); @(negedge clk);
      check("ack_one_cycle", {31'd0, avs_waitrequest}, 32'd1);
      check("rdata_idle_zero", avs_readdata, 32'd0);

      // RX data path
      host_push(8'hA5);
      host_push(8'h3C);
      rd_chk("rx_a5", 5'd0, 32'hA5);
      rd_chk("rx_3c", 5'd0, 32'h3C);
      rd_chk("status_rx_empty", 5'd8, 32'h40);

      // Underflow sticky, cleared by status read
      rd_chk("rx_underflow_data", 5'd0, 32'h00);
      rd_chk("status_udf", 5'd8, 32'h41);
      rd_chk("status_udf_clr", 5'd8, 32'h40);

      // TX fill, full status, stall and drain
      tx_ready = 1'b0;
      for (int i = 0; i < 32; i++) wr_do(5'd4, 8'(8'h11 + i));
      check("tx_valid_full", {31'd0, tx_valid}, 32'd1);
      rd_chk("status_tx_full", 5'd8, 32'h00);
      avs_write = 1'b1; avs_address = 5'd4; avs_writedata = 32'h31;
      low_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (!avs_waitrequest) low_cnt++;
      end
      check("tx_stall", low_cnt, 32'd0);
      tx_ready = 1'b1;
      ntx = 0; order_err = 0; acked = 0; first_tx = '0;
      for (int i = 0; i < 300 && !(acked && ntx >= 33); i++) begin
         if (tx_valid) begin
            if (ntx == 0) first_tx = tx_data;
            if (tx_data != 8'(8'h11 + ntx)) order_err++;
            ntx++;
         end
         if (avs_write && !avs_waitrequest) begin
            avs_write = 1'b0; acked = 1;
         end
         @(posedge clk); @(negedge clk);
      end
      avs_write = 1'b0;
      check("tx_stall_acked", {31'd0, acked}, 32'd1);
      check("tx_first", {24'd0, first_tx}, 32'h11);
      check("tx_count", ntx, 32'd33);
      check("tx_order", order_err, 32'd0);
      check("tx_drained", {31'd0, tx_valid}, 32'd0);

      // RX full: simultaneous host push and master pop
      for (int i = 0; i < 64; i++) host_push(8'(8'h40 + i));
      check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
      rd_chk("status_rx_full", 5'd8, 32'hC0);
      rx_valid = 1'b1; rx_data = 8'hEE;
      avs_read = 1'b1; avs_address = 5'd0;
      bad_rdy = 0; acked = 0;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(posedge clk); @(negedge clk);
         if (!avs_waitrequest) begin
            acked = 1;
            check("rx_full_pop_data", avs_readdata, 32'h40);
            check("rx_full_ready_ack", {31'd0, rx_ready}, 32'd1);
            avs_read = 1'b0;
         end else if (rx_ready) bad_rdy++;
      end
      avs_read = 1'b0;
      check("rx_full_ready_wait", bad_rdy, 32'd0);
      @(posedge clk); @(negedge clk);
      check("rx_full_ready_after", {31'd0, rx_ready}, 32'd0);
      rx_valid = 1'b0;
      order_err = 0;
      for (int i = 1; i < 64; i++) begin
         xfer(1'b1, 1'b0, 5'd0, 32'd0, d, lat);
         if (d != 32'(8'h40 + i)) order_err++;
      end
      check("rx_full_order", order_err, 32'd0);
      rd_chk("rx_full_last", 5'd0, 32'hEE);
      rd_chk("status_rx_drained", 5'd8, 32'h40);

      // Read+write together acts as read; unmapped/read-only registers
      xfer(1'b1, 1'b1, 5'd4, 32'h99, d, lat);
      check("rdwr_as_read", d, 32'd0);
      @(posedge clk); @(negedge clk);
      check("rdwr_no_push", {31'd0, tx_valid}, 32'd0);
      wr_do(5'd0, 8'h55);
      rd_chk("write0_ignored", 5'd8, 32'h40);
      rd_chk("unmapped_20", 5'd20, 32'd0);

      // Reset mid-transfer discards FIFOs
      tx_ready = 1'b0;
      wr_do(5'd4, 8'h77);
      host_push(8'h12);
      avs_read = 1'b1; avs_address = 5'd8;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      avs_read = 1'b0;
      @(negedge clk);
      check("midrst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
      check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      rd_chk("midrst_status", 5'd8, 32'h40);
      tx_ready = 1'b1;

      // Statistics counters
      host_push(8'h01); host_push(8'h02); host_push(8'h03);
      for (int i = 0; i < 3; i++) rd_chk("stats_rx_rd", 5'd0, 32'(i + 1));
      rd_chk("stats_udf_pop", 5'd0, 32'd0);
      for (int i = 0; i < 5; i++) wr_do(5'd4, 8'(8'h60 + i));
`ifdef RS232_STATS_EN
      rd_chk("stats_rx_pops", 5'd12, 32'd3);
      rd_chk("stats_tx_pushes", 5'd16, 32'd5);
`else
      rd_chk("stats_rx_pops", 5'd12, 32'd0);
      rd_chk("stats_tx_pushes", 5'd16, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
